// File: rtl/edge_period_meter.sv
// Measures period and high time of a slow asynchronous input in system clock cycles.
// Completed periods are offered on a valid/ready port with overrun and stuck flags.
module edge_period_meter #(
    parameter int CNT_W   = 25,
    parameter int TIMEOUT = 20000000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun,
    output logic             stuck
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] high_cnt;
    logic             rise;
    logic             fall;
    logic             load;
    logic             accept;

    // Two-flop synchronizer followed by an edge register for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise   = s2 & ~s3;
    assign fall   = ~s2 & s3;
    assign load   = (state == MEASURE) && rise;
    assign accept = meas_valid && meas_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            high_cnt   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (rise) begin
                        state <= MEASURE;
                        count <= 1;
                    end
                end
                MEASURE: begin
                    // A rise on the timeout cycle still wins and yields a result
                    if (rise) begin
                        count <= 1;
                    end else if (count == TIMEOUT_C) begin
                        stuck    <= 1'b1;
                        state    <= IDLE;
                        count    <= '0;
                        high_cnt <= '0;
                    end else begin
                        count <= count + 1'b1;
                        if (fall) begin
                            high_cnt <= count;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase

            // A fresh result beats a simultaneous accept, keeping valid high
            if (load) begin
                period     <= count;
                high_time  <= high_cnt;
                meas_valid <= 1'b1;
                stuck      <= 1'b0;
                if (meas_valid && !meas_ready) begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                meas_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_period_meter.sv
// Self-checking bench for edge_period_meter: timestamp-based reference model compared
// every cycle, plus literal expectations for each scenario.
module tb_edge_period_meter;

    localparam int CW = 25;
    localparam int TO = 5000;

    logic          clock      = 1'b0;
    logic          reset_n    = 1'b0;
    logic          sig_in     = 1'b0;
    logic          meas_ready = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          overrun;
    logic          stuck;

    int testsRun    = 0;
    int testsFailed = 0;

    int cyc        = 0;
    int lastRise   = 0;
    int highCnt    = 0;
    int newP       = 0;
    int newH       = 0;
    int mPeriod    = 0;
    int mHigh      = 0;
    int validTotal = 0;
    bit armed      = 1'b0;
    bit mValid     = 1'b0;
    bit mOverrun   = 1'b0;
    bit mStuck     = 1'b0;
    bit p1         = 1'b0;
    bit p2         = 1'b0;
    bit p3         = 1'b0;
    bit riseNow    = 1'b0;
    bit fallNow    = 1'b0;
    bit loadNow    = 1'b0;

    always #5 clock = ~clock;

    edge_period_meter #(
        .CNT_W  (CW),
        .TIMEOUT(TO)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .meas_ready(meas_ready),
        .overrun   (overrun),
        .stuck     (stuck)
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: edges are seen a fixed number of samples after sig_in moves,
    // and results are differences between edge timestamps
    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                armed    = 1'b0;
                highCnt  = 0;
                mPeriod  = 0;
                mHigh    = 0;
                mValid   = 1'b0;
                mOverrun = 1'b0;
                mStuck   = 1'b0;
                p1       = 1'b0;
                p2       = 1'b0;
                p3       = 1'b0;
            end else begin
                cyc++;
                riseNow = p2 && !p3;
                fallNow = !p2 && p3;
                loadNow = 1'b0;
                if (armed) begin
                    if (riseNow) begin
                        loadNow  = 1'b1;
                        newP     = cyc - lastRise;
                        newH     = highCnt;
                        lastRise = cyc;
                    end else if (cyc - lastRise == TO) begin
                        mStuck  = 1'b1;
                        armed   = 1'b0;
                        highCnt = 0;
                    end else if (fallNow) begin
                        highCnt = cyc - lastRise;
                    end
                end else if (riseNow) begin
                    armed    = 1'b1;
                    lastRise = cyc;
                end
                if (loadNow) begin
                    if (mValid && !meas_ready) mOverrun = 1'b1;
                    mValid  = 1'b1;
                    mPeriod = newP;
                    mHigh   = newH;
                    mStuck  = 1'b0;
                end else if (mValid && meas_ready) begin
                    mValid   = 1'b0;
                    mOverrun = 1'b0;
                end
                p3 = p2;
                p2 = p1;
                p1 = sig_in;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                checkOutput("cmp period", longint'(period), longint'(mPeriod));
                checkOutput("cmp high_time", longint'(high_time), longint'(mHigh));
                checkOutput("cmp meas_valid", longint'(meas_valid), longint'(mValid));
                checkOutput("cmp overrun", longint'(overrun), longint'(mOverrun));
                checkOutput("cmp stuck", longint'(stuck), longint'(mStuck));
                if (meas_valid) validTotal++;
            end
        end
    end

    task automatic driveLevel(input bit v, input int n);
        sig_in = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            driveLevel(1'b1, hi);
            driveLevel(1'b0, per - hi);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " period"}, longint'(period), 0);
        checkOutput({tag, " high_time"}, longint'(high_time), 0);
        checkOutput({tag, " meas_valid"}, longint'(meas_valid), 0);
        checkOutput({tag, " overrun"}, longint'(overrun), 0);
        checkOutput({tag, " stuck"}, longint'(stuck), 0);
    endtask

    initial begin
        int base;
        int baseRel;

        repeat (3) @(negedge clock);
        checkAllZero("reset");
        reset_n    = 1'b1;
        meas_ready = 1'b1;

        // Free-running square wave, consumer always ready
        base = validTotal;
        applyStimulus(1000, 300, 4);
        checkOutput("wave results", longint'(validTotal - base), 3);
        checkOutput("wave period", longint'(period), 1000);
        checkOutput("wave high", longint'(high_time), 300);
        checkOutput("wave overrun", longint'(overrun), 0);
        checkOutput("wave stuck", longint'(stuck), 0);

        // Input stops: timeout, then recovery needs two rises
        driveLevel(1'b0, 5100);
        checkOutput("timeout stuck", longint'(stuck), 1);
        checkOutput("timeout valid", longint'(meas_valid), 0);
        base = validTotal;
        applyStimulus(1000, 300, 2);
        checkOutput("resume results", longint'(validTotal - base), 1);
        checkOutput("resume period", longint'(period), 1000);
        checkOutput("resume stuck", longint'(stuck), 0);

        // Consumer stalled: first result holds, second overwrites
        meas_ready = 1'b0;
        applyStimulus(200, 100, 1);
        checkOutput("hold period", longint'(period), 1000);
        checkOutput("hold high", longint'(high_time), 300);
        checkOutput("hold valid", longint'(meas_valid), 1);
        checkOutput("hold overrun", longint'(overrun), 0);
        applyStimulus(200, 100, 2);
        checkOutput("overwrite period", longint'(period), 200);
        checkOutput("overwrite high", longint'(high_time), 100);
        checkOutput("overwrite overrun", longint'(overrun), 1);
        meas_ready = 1'b1;
        @(negedge clock);
        meas_ready = 1'b0;
        checkOutput("accept valid", longint'(meas_valid), 0);
        checkOutput("accept overrun", longint'(overrun), 0);

        // Ready coincides with a new result loading
        applyStimulus(200, 100, 1);
        checkOutput("pre-coincide valid", longint'(meas_valid), 1);
        sig_in = 1'b1;
        repeat (2) @(negedge clock);
        meas_ready = 1'b1;
        @(negedge clock);
        meas_ready = 1'b0;
        checkOutput("coincide valid", longint'(meas_valid), 1);
        checkOutput("coincide overrun", longint'(overrun), 0);
        checkOutput("coincide period", longint'(period), 200);
        checkOutput("coincide high", longint'(high_time), 100);
        driveLevel(1'b1, 97);
        driveLevel(1'b0, 100);
        meas_ready = 1'b1;
        @(negedge clock);

        // Reset mid-measurement with sig_in high at release
        driveLevel(1'b1, 500);
        #2 reset_n = 1'b0;
        #1 checkAllZero("midreset");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        baseRel = validTotal;
        driveLevel(1'b1, 100);
        driveLevel(1'b0, 300);
        checkOutput("post-reset no result", longint'(validTotal - baseRel), 0);
        applyStimulus(400, 100, 2);
        checkOutput("post-reset results", longint'(validTotal - baseRel), 2);
        checkOutput("post-reset period", longint'(period), 400);
        checkOutput("post-reset high", longint'(high_time), 100);

        // Fastest supported input: toggling every two clocks
        base = validTotal;
        applyStimulus(4, 2, 10);
        checkOutput("min results", longint'(validTotal - base), 10);
        checkOutput("min period", longint'(period), 4);
        checkOutput("min high", longint'(high_time), 2);
        checkOutput("min overrun", longint'(overrun), 0);
        repeat (10) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
